// File: rtl/riscky_ctrl.sv
// riscky_ctrl: multicycle control FSM for a small RISC-V style core.
// Optional build macro: RISCKY_CTRL_ILLEGAL_TRAP_EN
//   defined   -> unknown opcodes park the FSM in TRAP with illegal_instr=1 until reset
//   undefined -> unknown opcodes are treated as a NOP; illegal_instr is tied low
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 written back on mem_ready
// DECODE   | branch target precompute, dispatch on opcode
// MEMADR   | effective address = rs1 + imm (I for load, S for store)
// MEMREAD  | load data access, held until mem_ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store data access, held until mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU-out register to register file
// JAL      | PC <- jump target, link value computed as old PC + 4
// BRANCH   | compare rs1/rs2, PC <- target when taken
// TRAP     | illegal opcode seen, parked until reset (optional)

package riscky_pkg;
    localparam int ILEN = 32;
endpackage

module riscky_ctrl
    import riscky_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ILEN-1:0] instr,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic            mem_req,
    output logic            mem_we,
    output logic            adr_sel,
    output logic            ir_we,
    output logic            pc_we,
    output logic            reg_we,
    output logic [1:0]      imm_sel,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      result_sel,
    output logic            illegal_instr
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
`ifdef RISCKY_CTRL_ILLEGAL_TRAP_EN
        BRANCH   = 4'd10,
        TRAP     = 4'd11
`else
        BRANCH   = 4'd10
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q, state_d;
    // run_q keeps the first fetch off the bus until the first edge after reset release
    logic   run_q, run_d;

    logic [6:0] opcode;
    assign opcode = instr[6:0];

    // State and run-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_sel    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        imm_sel    = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_sel = 2'b00;

        unique case (state_q)
            FETCH: begin
                mem_req    = run_q;
                alu_src_b  = 2'b10;
                result_sel = 2'b10;
                ir_we      = run_q & mem_ready;
                pc_we      = run_q & mem_ready;
                if (run_q && mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_sel   = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BRANCH:         state_d = BRANCH;
`ifdef RISCKY_CTRL_ILLEGAL_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_STORE) begin
                    imm_sel = 2'b01;
                    state_d = MEMWRITE;
                end else begin
                    state_d = MEMREAD;
                end
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_sel = 2'b01;
                reg_we     = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_we  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                imm_sel   = 2'b11;
                pc_we     = 1'b1;
                state_d   = ALUWB;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                imm_sel   = 2'b10;
                // instr[12] distinguishes BNE from BEQ
                pc_we     = alu_zero ^ instr[12];
                state_d   = FETCH;
            end
`ifdef RISCKY_CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

`ifdef RISCKY_CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_riscky_ctrl.sv
// Scoreboard bench for riscky_ctrl: stimulus pushes the hand-computed output
// vector for each cycle, a monitor pops and compares on the falling edge.
module tb_riscky_ctrl;
    import riscky_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ILEN-1:0] instr = '0;
    logic            mem_ready = 1'b0;
    logic            alu_zero = 1'b0;
    logic            mem_req, mem_we, adr_sel, ir_we, pc_we, reg_we, illegal_instr;
    logic [1:0]      imm_sel, alu_src_a, alu_src_b, alu_op, result_sel;

    riscky_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .mem_req(mem_req), .mem_we(mem_we), .adr_sel(adr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_sel(result_sel), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] vec;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    // field order: req we adr ir pc reg imm[2] a[2] b[2] op[2] res[2] ill
    function automatic logic [16:0] o(logic rq, logic we, logic ad, logic ir, logic pc,
                                      logic rg, logic [1:0] im, logic [1:0] a,
                                      logic [1:0] b, logic [1:0] op, logic [1:0] rs,
                                      logic il);
        return {rq, we, ad, ir, pc, rg, im, a, b, op, rs, il};
    endfunction

    logic [16:0] v_rst, v_fwait, v_fetch, v_dec, v_madr_l, v_madr_s, v_mread, v_mwb;
    logic [16:0] v_mwr, v_execr, v_execi, v_aluwb, v_jal, v_br_t, v_br_n, v_trap;

    initial begin
        v_rst    = o(0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,2'b10,0);
        v_fwait  = o(1,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,2'b10,0);
        v_fetch  = o(1,0,0,1,1,0,2'b00,2'b00,2'b10,2'b00,2'b10,0);
        v_dec    = o(0,0,0,0,0,0,2'b10,2'b01,2'b01,2'b00,2'b00,0);
        v_madr_l = o(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0);
        v_madr_s = o(0,0,0,0,0,0,2'b01,2'b10,2'b01,2'b00,2'b00,0);
        v_mread  = o(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0);
        v_mwb    = o(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b01,0);
        v_mwr    = o(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0);
        v_execr  = o(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0);
        v_execi  = o(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0);
        v_aluwb  = o(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0);
        v_jal    = o(0,0,0,0,1,0,2'b11,2'b01,2'b10,2'b00,2'b00,0);
        v_br_t   = o(0,0,0,0,1,0,2'b10,2'b10,2'b00,2'b01,2'b00,0);
        v_br_n   = o(0,0,0,0,0,0,2'b10,2'b10,2'b00,2'b01,2'b00,0);
        v_trap   = o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1);
    end

    // One clock cycle of stimulus: drive after the rising edge, queue the expectation
    task automatic cyc(input logic rst, input logic [ILEN-1:0] ins, input logic rdy,
                       input logic z, input logic [16:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rst;
        instr     = ins;
        mem_ready = rdy;
        alu_zero  = z;
        x.vec  = e;
        x.name = nm;
        q.push_back(x);
    endtask

    localparam logic [ILEN-1:0] I_LW   = 32'h0000_2003;
    localparam logic [ILEN-1:0] I_SW   = 32'h0000_2023;
    localparam logic [ILEN-1:0] I_BEQ  = 32'h0000_0063;
    localparam logic [ILEN-1:0] I_BNE  = 32'h0000_1063;
    localparam logic [ILEN-1:0] I_JAL  = 32'h0000_006F;
    localparam logic [ILEN-1:0] I_ADD  = 32'h0000_0033;
    localparam logic [ILEN-1:0] I_ADDI = 32'h0000_0013;
    localparam logic [ILEN-1:0] I_BAD  = 32'h0000_007F;

    // Monitor: compare DUT outputs against the queued expectation each falling edge
    always @(negedge clk) begin
        exp_t        x;
        logic [16:0] act;
        if (q.size() > 0) begin
            x   = q.pop_front();
            act = {mem_req, mem_we, adr_sel, ir_we, pc_we, reg_we, imm_sel, alu_src_a,
                   alu_src_b, alu_op, result_sel, illegal_instr};
            n_tests++;
            if (act !== x.vec) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", x.name, act, x.vec);
            end
        end
    end

    // Directed stimulus
    initial begin
        cyc(0, I_LW, 1, 0, v_rst, "reset_idle");
        cyc(0, I_LW, 1, 0, v_rst, "reset_idle_rdy");
        cyc(1, I_LW, 1, 0, v_rst, "release_no_req");

        // lw with one wait cycle in FETCH, then 5 cycles
        cyc(1, I_LW, 0, 0, v_fwait,  "lw_fetch_wait");
        cyc(1, I_LW, 1, 0, v_fetch,  "lw_fetch");
        cyc(1, I_LW, 1, 0, v_dec,    "lw_decode");
        cyc(1, I_LW, 1, 0, v_madr_l, "lw_memadr");
        cyc(1, I_LW, 1, 0, v_mread,  "lw_memread");
        cyc(1, I_LW, 1, 0, v_mwb,    "lw_memwb");

        // sw with three wait cycles in MEMWRITE
        cyc(1, I_SW, 1, 0, v_fetch,  "sw_fetch");
        cyc(1, I_SW, 1, 0, v_dec,    "sw_decode");
        cyc(1, I_SW, 0, 0, v_madr_s, "sw_memadr");
        cyc(1, I_SW, 0, 0, v_mwr,    "sw_memwrite_w1");
        cyc(1, I_SW, 0, 0, v_mwr,    "sw_memwrite_w2");
        cyc(1, I_SW, 0, 0, v_mwr,    "sw_memwrite_w3");
        cyc(1, I_SW, 1, 0, v_mwr,    "sw_memwrite_done");

        // beq taken, bne not taken with alu_zero=1
        cyc(1, I_BEQ, 1, 1, v_fetch, "beq_fetch");
        cyc(1, I_BEQ, 1, 1, v_dec,   "beq_decode");
        cyc(1, I_BEQ, 1, 1, v_br_t,  "beq_branch_taken");
        cyc(1, I_BNE, 1, 1, v_fetch, "bne_fetch");
        cyc(1, I_BNE, 1, 1, v_dec,   "bne_decode");
        cyc(1, I_BNE, 1, 1, v_br_n,  "bne_branch_not_taken");
        // bne with alu_zero=0 is taken
        cyc(1, I_BNE, 1, 0, v_fetch, "bne2_fetch");
        cyc(1, I_BNE, 1, 0, v_dec,   "bne2_decode");
        cyc(1, I_BNE, 1, 0, v_br_t,  "bne2_branch_taken");

        // jal
        cyc(1, I_JAL, 1, 0, v_fetch, "jal_fetch");
        cyc(1, I_JAL, 1, 0, v_dec,   "jal_decode");
        cyc(1, I_JAL, 1, 0, v_jal,   "jal_jal");
        cyc(1, I_JAL, 1, 0, v_aluwb, "jal_aluwb");

        // R and I types
        cyc(1, I_ADD, 1, 0, v_fetch,  "add_fetch");
        cyc(1, I_ADD, 1, 0, v_dec,    "add_decode");
        cyc(1, I_ADD, 1, 0, v_execr,  "add_execr");
        cyc(1, I_ADD, 1, 0, v_aluwb,  "add_aluwb");
        cyc(1, I_ADDI, 1, 0, v_fetch, "addi_fetch");
        cyc(1, I_ADDI, 1, 0, v_dec,   "addi_decode");
        cyc(1, I_ADDI, 1, 0, v_execi, "addi_execi");
        cyc(1, I_ADDI, 1, 0, v_aluwb, "addi_aluwb");

        // reset asserted mid-MEMREAD with mem_ready low
        cyc(1, I_LW, 1, 0, v_fetch,  "rlw_fetch");
        cyc(1, I_LW, 1, 0, v_dec,    "rlw_decode");
        cyc(1, I_LW, 0, 0, v_madr_l, "rlw_memadr");
        cyc(1, I_LW, 0, 0, v_mread,  "rlw_memread_wait");
        cyc(0, I_LW, 1, 0, v_rst,    "rlw_async_reset");
        cyc(0, I_LW, 1, 0, v_rst,    "rlw_reset_held");
        cyc(1, I_LW, 1, 0, v_rst,    "rlw_release");
        cyc(1, I_LW, 1, 0, v_fetch,  "rlw_first_fetch");
        cyc(1, I_LW, 1, 0, v_dec,    "rlw_decode2");

        // unknown opcode: remaining lw finishes first
        cyc(1, I_LW, 1, 0, v_madr_l, "rlw_memadr2");
        cyc(1, I_LW, 1, 0, v_mread,  "rlw_memread2");
        cyc(1, I_LW, 1, 0, v_mwb,    "rlw_memwb2");
        cyc(1, I_BAD, 1, 0, v_fetch, "bad_fetch");
        cyc(1, I_BAD, 1, 0, v_dec,   "bad_decode");
`ifdef RISCKY_CTRL_ILLEGAL_TRAP_EN
        cyc(1, I_BAD, 1, 0, v_trap,  "bad_trap1");
        cyc(1, I_ADD, 1, 0, v_trap,  "bad_trap2");
        cyc(1, I_ADD, 1, 0, v_trap,  "bad_trap3");
        cyc(0, I_ADD, 1, 0, v_rst,   "trap_reset");
        cyc(1, I_ADD, 1, 0, v_rst,   "trap_release");
`else
        cyc(1, I_ADD, 1, 0, v_fetch, "bad_nop_fetch");
        cyc(1, I_ADD, 1, 0, v_dec,   "bad_nop_decode");
        cyc(1, I_ADD, 1, 0, v_execr, "bad_nop_execr");
        cyc(1, I_ADD, 1, 0, v_aluwb, "bad_nop_aluwb");
`endif
        cyc(1, I_ADD, 1, 0, v_fetch, "tail_fetch");
        cyc(1, I_ADD, 1, 0, v_dec,   "tail_decode");
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then summarise
    initial begin
        int guard;
        guard = 0;
        wait (stim_done);
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL count: %0d comparisons, expected at least 12", n_tests);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
